bitstream_loader: RTL

Byte-wide configuration front end for the tiny FPGA fabric. Packs bytes from the chip pins into `BITSTREAM_DATA_WIDTH`-bit words and drives them onto the fabric's AXI-stream configuration port. It frames the words per CLB with `tlast` and pulses the fabric's `cfg` request. It sits directly upstream of the 2x2 fabric top, between the pin-level input logic and the fabric's `cfg` / `cfg_bitstream` inputs.

---
 rtl/axi_stream_if.sv | 29 ++
 rtl/bitstream_loader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/axi_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_if
// Brief    : Minimal AXI-stream bundle (tdata/tvalid/tready/tlast).
// Revision : 1.0
// ============================================================================
interface axi_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : bitstream_loader
// Brief    : Packs pin-level config bytes into stream words framed per CLB.
// Revision : 1.0
// ============================================================================
module bitstream_loader #(
    parameter int BITSTREAM_DATA_WIDTH = 16,
    parameter int WORDS_PER_CLB        = 2,
    parameter int CLB_COUNT            = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         cfg,
    axi_stream_if.master cfg_bitstream,
    output logic         busy,
    output logic         done
);
    localparam int c_BYTES_PER_WORD = BITSTREAM_DATA_WIDTH / 8;
    localparam int c_BIDX_W = (c_BYTES_PER_WORD > 1) ? $clog2(c_BYTES_PER_WORD) : 1;
    localparam int c_WIDX_W = (WORDS_PER_CLB > 1) ? $clog2(WORDS_PER_CLB) : 1;
    localparam int c_CIDX_W = (CLB_COUNT > 1) ? $clog2(CLB_COUNT) : 1;

    localparam logic [c_BIDX_W-1:0] c_LAST_BYTE = c_BIDX_W'(c_BYTES_PER_WORD - 1);
    localparam logic [c_WIDX_W-1:0] c_LAST_WORD = c_WIDX_W'(WORDS_PER_CLB - 1);
    localparam logic [c_CIDX_W-1:0] c_LAST_CLB  = c_CIDX_W'(CLB_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_PACK = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [c_BIDX_W-1:0]            r_byte_idx;
    logic [c_WIDX_W-1:0]            r_word_idx;
    logic [c_CIDX_W-1:0]            r_clb_idx;
    logic [BITSTREAM_DATA_WIDTH-1:0] r_shift;
    logic [BITSTREAM_DATA_WIDTH-1:0] r_tdata;
    logic                           r_tvalid;
    logic                           r_tlast;
    logic [BITSTREAM_DATA_WIDTH-1:0] w_word;
    logic                           w_byte_last;
    logic                           w_hs;

    assign w_byte_last = (r_byte_idx == c_LAST_BYTE);
    assign w_hs        = r_tvalid && cfg_bitstream.tready;

    assign cfg_bitstream.tdata  = r_tdata;
    assign cfg_bitstream.tvalid = r_tvalid;
    assign cfg_bitstream.tlast  = r_tlast;

    // Current byte merged into its little-endian slot of the word under assembly
    always_comb begin
        w_word = r_shift;
        w_word[8*int'(r_byte_idx) +: 8] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        cfg      = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                cfg    = 1'b1;
                w_next = S_PACK;
            end
            S_PACK: begin
                in_ready = 1'b1;
                if (in_valid && w_byte_last) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_hs) begin
                    w_next = (r_tlast && (r_clb_idx == c_LAST_CLB)) ? S_DONE : S_PACK;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_clb_idx  <= '0;
            r_shift    <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_byte_idx <= '0;
                    r_word_idx <= '0;
                    r_clb_idx  <= '0;
                    r_shift    <= '0;
                end
                S_PACK: begin
                    if (in_valid) begin
                        r_shift <= w_word;
                        if (w_byte_last) begin
                            r_tdata    <= w_word;
                            r_tvalid   <= 1'b1;
                            r_tlast    <= (r_word_idx == c_LAST_WORD);
                            r_byte_idx <= '0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        if (!r_tlast) begin
                            r_word_idx <= r_word_idx + 1'b1;
                        end else if (r_clb_idx != c_LAST_CLB) begin
                            r_word_idx <= '0;
                            r_clb_idx  <= r_clb_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
`default_nettype wire
